// File: rtl/cordic_byte_frame_adapter_if.sv
// Byte-pin, CORDIC request and result signals of the byte frame adapter.
// The slave modport is the adapter; the master modport is its environment.
interface cordic_byte_frame_adapter_if #(
  parameter int DATA_W = 16,
  parameter int N_IN   = 2,
  parameter int RES_W  = 48
);
  logic [7:0]             in_data;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [N_IN*DATA_W-1:0] req_data;
  logic                   req_mode;
  logic                   req_valid;
  logic                   req_ready;
  logic [RES_W-1:0]       rsp_data;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic                   busy;
  logic                   err;

  modport slave (
    input  in_data, in_valid, out_ready, req_ready, rsp_data, rsp_valid,
    output in_ready, out_data, out_valid, req_data, req_mode, req_valid,
           rsp_ready, busy, err
  );

  modport master (
    output in_data, in_valid, out_ready, req_ready, rsp_data, rsp_valid,
    input  in_ready, out_data, out_valid, req_data, req_mode, req_valid,
           rsp_ready, busy, err
  );
endinterface

// File: rtl/cordic_byte_frame_adapter.sv
// Half-duplex byte-serial framing adapter in front of a parallel CORDIC core.
//
// state | meaning
// HDR   | waiting for the command byte (bit 0 = rotation mode)
// LOAD  | collecting operand bytes, operand 0 first, LSB byte first
// ISSUE | parallel request presented to the core
// WAIT  | waiting for the core result
// SEND  | serialising the result, LSB byte first
module cordic_byte_frame_adapter #(
  parameter int DATA_W  = 16,
  parameter int N_IN    = 2,
  parameter int RES_W   = 48,
  parameter int TIMEOUT = 255
) (
  input logic                    clk,
  input logic                    rst_n,
  cordic_byte_frame_adapter_if.slave bus
);
  localparam int NB_IN  = N_IN * DATA_W / 8;
  localparam int NB_OUT = RES_W / 8;
  localparam int NB_MAX = (NB_IN > NB_OUT) ? NB_IN : NB_OUT;
  localparam int BW     = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;
  localparam int IW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [BW-1:0] IN_LAST   = BW'(NB_IN - 1);
  localparam logic [BW-1:0] OUT_LAST  = BW'(NB_OUT - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {HDR, LOAD, ISSUE, WAIT, SEND} state_t;

  state_t                 state;
  logic [BW-1:0]          bcnt;
  logic [IW-1:0]          idle;
  logic [N_IN*DATA_W-1:0] opr;
  logic [RES_W-1:0]       res;
  logic [RES_W-1:0]       res_sh;
  logic                   mode;
  logic                   in_ready_r;
  logic                   out_valid_r;
  logic [7:0]             out_data_r;
  logic                   req_valid_r;
  logic                   rsp_ready_r;
  logic                   busy_r;
  logic                   err_r;
  logic                   in_acc;

  assign in_acc = bus.in_valid && in_ready_r;
  assign res_sh = res >> 8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HDR;
      bcnt        <= '0;
      idle        <= '0;
      opr         <= '0;
      res         <= '0;
      mode        <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= 8'h00;
      req_valid_r <= 1'b0;
      rsp_ready_r <= 1'b0;
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      err_r <= 1'b0;
      case (state)
        HDR: begin
          if (in_acc) begin
            mode   <= bus.in_data[0];
            bcnt   <= '0;
            idle   <= '0;
            busy_r <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (in_acc) begin
            for (int i = 0; i < NB_IN; i++) begin
              if (int'(bcnt) == i) opr[i*8 +: 8] <= bus.in_data;
            end
            idle <= '0;
            if (bcnt == IN_LAST) begin
              bcnt        <= '0;
              in_ready_r  <= 1'b0;
              req_valid_r <= 1'b1;
              state       <= ISSUE;
            end else begin
              bcnt <= bcnt + 1'b1;
            end
          end else if (TIMEOUT > 0) begin
            // A byte on the final idle cycle wins over the timeout.
            if (idle == IDLE_LAST) begin
              err_r  <= 1'b1;
              bcnt   <= '0;
              idle   <= '0;
              busy_r <= 1'b0;
              state  <= HDR;
            end else begin
              idle <= idle + 1'b1;
            end
          end
        end
        ISSUE: begin
          if (bus.req_ready) begin
            req_valid_r <= 1'b0;
            rsp_ready_r <= 1'b1;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (bus.rsp_valid) begin
            res         <= bus.rsp_data;
            out_data_r  <= bus.rsp_data[7:0];
            out_valid_r <= 1'b1;
            rsp_ready_r <= 1'b0;
            bcnt        <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (bus.out_ready) begin
            if (bcnt == OUT_LAST) begin
              bcnt        <= '0;
              out_valid_r <= 1'b0;
              in_ready_r  <= 1'b1;
              busy_r      <= 1'b0;
              state       <= HDR;
            end else begin
              // Next byte is loaded on the transfer edge so there is no bubble.
              bcnt       <= bcnt + 1'b1;
              res        <= res_sh;
              out_data_r <= res_sh[7:0];
            end
          end
        end
        default: state <= HDR;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.req_valid = req_valid_r;
  assign bus.req_data  = opr;
  assign bus.req_mode  = mode;
  assign bus.rsp_ready = rsp_ready_r;
  assign bus.busy      = busy_r;
  assign bus.err       = err_r;
endmodule
